// File: rtl/player_physics_if.sv
// Frame-rate bus between the wave generator / game FSM and the surfer physics engine.
// The master supplies vsync, mode and surface height; the slave returns player state.
interface player_physics_if;
   logic              vsync;
   logic              active;
   logic [9:0]        wave_height;
   logic              wave_ready;
   logic [9:0]        p_vpos;
   logic signed [7:0] velocity;
   logic [1:0]        char_frame;
   logic              airborne;
   logic              landed;

   modport master (
      output vsync, active, wave_height, wave_ready,
      input  p_vpos, velocity, char_frame, airborne, landed
   );

   modport slave (
      input  vsync, active, wave_height, wave_ready,
      output p_vpos, velocity, char_frame, airborne, landed
   );
endinterface

// File: rtl/player_physics.sv
// Per-frame vertical motion of the surfer: rides the wave surface, launches into a
// ballistic arc when the surface falls away too quickly, and lands back on the wave.
module player_physics #(
   parameter int CHAR_HEIGHT = 20,
   parameter int GRAVITY     = 1,
   parameter int MAX_FALL    = 8,
   parameter int LAUNCH_DROP = 3,
   parameter int TOP_LIMIT   = 16,
   parameter int INIT_VPOS   = 300
) (
   input  logic             clock,
   input  logic             reset_n,
   player_physics_if.slave  bus
);

   localparam logic [0:0] ST_RIDING   = 1'b0;
   localparam logic [0:0] ST_AIRBORNE = 1'b1;

   localparam logic signed [11:0] K_CHAR  = 12'(CHAR_HEIGHT);
   localparam logic signed [11:0] K_GRAV  = 12'(GRAVITY);
   localparam logic signed [11:0] K_MAXF  = 12'(MAX_FALL);
   localparam logic signed [11:0] K_DROP  = 12'(LAUNCH_DROP);
   localparam logic signed [11:0] K_TOP   = 12'(TOP_LIMIT);
   localparam logic signed [11:0] K_VMIN  = -12'sd128;
   localparam logic signed [11:0] K_ZERO  = 12'sd0;

   logic              vsync_q_reg;
   logic [9:0]        wave_q_reg;
   logic [0:0]        state_reg,      state_next;
   logic [9:0]        p_vpos_reg;
   logic signed [7:0] velocity_reg;
   logic [1:0]        char_frame_reg, char_frame_next;
   logic              landed_reg,     landed_next;

   logic signed [11:0] p_vpos_next;
   logic signed [11:0] velocity_next;

   logic              tick;
   logic [9:0]        wave_src;
   logic signed [11:0] wave_s;
   logic signed [11:0] tgt_raw;
   logic signed [11:0] tgt;
   logic signed [11:0] pos_s;
   logic signed [11:0] vel_s;
   logic signed [11:0] vel_inc;
   logic signed [11:0] nv;
   logic signed [11:0] np;
   logic signed [11:0] d;
   logic signed [11:0] d_clamped;

   assign tick = bus.vsync & ~vsync_q_reg;

   // A wave sample arriving on the tick cycle itself is newer than wave_q, so use it.
   assign wave_src = bus.wave_ready ? bus.wave_height : wave_q_reg;

   assign wave_s  = {2'b00, wave_src};
   assign tgt_raw = wave_s - K_CHAR;
   assign tgt     = (tgt_raw < K_ZERO) ? K_ZERO : tgt_raw;

   assign pos_s   = {2'b00, p_vpos_reg};
   assign vel_s   = {{4{velocity_reg[7]}}, velocity_reg};
   assign vel_inc = vel_s + K_GRAV;
   assign nv      = (vel_inc > K_MAXF) ? K_MAXF : vel_inc;
   assign np      = pos_s + nv;
   assign d       = tgt - pos_s;

   always_comb begin
      d_clamped = d;
      if (d < K_VMIN) begin
         d_clamped = K_VMIN;
      end else if (d > K_MAXF) begin
         d_clamped = K_MAXF;
      end
   end

   always_comb begin
      state_next    = state_reg;
      p_vpos_next   = pos_s;
      velocity_next = vel_s;
      landed_next   = 1'b0;

      if (tick) begin
         if (!bus.active) begin
            state_next    = ST_RIDING;
            p_vpos_next   = tgt;
            velocity_next = K_ZERO;
         end else if (state_reg == ST_RIDING) begin
            if (d <= K_DROP) begin
               p_vpos_next   = tgt;
               velocity_next = d_clamped;
            end else begin
               state_next = ST_AIRBORNE;
               if (np < K_TOP) begin
                  p_vpos_next   = K_TOP;
                  velocity_next = K_ZERO;
               end else begin
                  p_vpos_next   = np;
                  velocity_next = nv;
               end
            end
         end else begin
            if (np >= tgt) begin
               state_next    = ST_RIDING;
               p_vpos_next   = tgt;
               velocity_next = K_ZERO;
               landed_next   = 1'b1;
            end else if (np < K_TOP) begin
               p_vpos_next   = K_TOP;
               velocity_next = K_ZERO;
            end else begin
               p_vpos_next   = np;
               velocity_next = nv;
            end
         end
      end
   end

   // Animation frame follows the velocity that is about to be stored.
   always_comb begin
      char_frame_next = char_frame_reg;
      if (tick) begin
         if (velocity_next == K_ZERO) begin
            char_frame_next = 2'd0;
         end else if (velocity_next < K_ZERO) begin
            char_frame_next = 2'd1;
         end else begin
            char_frame_next = 2'd2;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vsync_q_reg    <= 1'b0;
         wave_q_reg     <= 10'(INIT_VPOS + CHAR_HEIGHT);
         state_reg      <= ST_RIDING;
         p_vpos_reg     <= 10'(INIT_VPOS);
         velocity_reg   <= 8'sd0;
         char_frame_reg <= 2'd0;
         landed_reg     <= 1'b0;
      end else begin
         vsync_q_reg    <= bus.vsync;
         if (bus.wave_ready) begin
            wave_q_reg <= bus.wave_height;
         end
         state_reg      <= state_next;
         p_vpos_reg     <= p_vpos_next[9:0];
         velocity_reg   <= velocity_next[7:0];
         char_frame_reg <= char_frame_next;
         landed_reg     <= landed_next;
      end
   end

   assign bus.p_vpos     = p_vpos_reg;
   assign bus.velocity   = velocity_reg;
   assign bus.char_frame = char_frame_reg;
   assign bus.airborne   = (state_reg == ST_AIRBORNE);
   assign bus.landed     = landed_reg;

endmodule

// File: tb/tb_player_physics.sv
// Scoreboard bench for player_physics: a frame-level model pushes expected state per
// vsync tick, and the DUT's registered outputs are popped and compared after the edge.
module tb_player_physics;

   logic clock;
   logic reset_n;

   player_physics_if bus ();

   player_physics dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int p;
      int v;
      int f;
      bit air;
      bit land;
   } exp_t;

   exp_t exp_q[$];

   int total = 0;
   int bad   = 0;

   int m_p, m_v, m_wave_q;
   bit m_air;

   localparam int MODE_PRE    = 0;
   localparam int MODE_BYPASS = 1;
   localparam int MODE_NONE   = 2;

   task automatic model_reset();
      m_p = 300; m_v = 0; m_air = 0; m_wave_q = 320;
   endtask

   task automatic model_tick(input int src, input bit act, output exp_t e);
      int tgt, d, nv, np;
      bit land;
      land = 0;
      tgt = src - 20;
      if (tgt < 0) tgt = 0;
      nv = m_v + 1;
      if (nv > 8) nv = 8;
      np = m_p + nv;
      if (!act) begin
         m_p = tgt; m_v = 0; m_air = 0;
      end else if (!m_air) begin
         d = tgt - m_p;
         if (d <= 3) begin
            m_p = tgt;
            m_v = (d < -128) ? -128 : d;
         end else begin
            m_air = 1;
            if (np < 16) begin m_p = 16; m_v = 0; end
            else begin m_p = np; m_v = nv; end
         end
      end else begin
         if (np >= tgt) begin
            m_p = tgt; m_v = 0; m_air = 0; land = 1;
         end else if (np < 16) begin
            m_p = 16; m_v = 0;
         end else begin
            m_p = np; m_v = nv;
         end
      end
      e.p = m_p;
      e.v = m_v;
      e.f = (m_v == 0) ? 0 : ((m_v < 0) ? 1 : 2);
      e.air = m_air;
      e.land = land;
   endtask

   // One frame: optional wave sample, vsync rising edge, compare, then hold vsync high
   // to confirm nothing moves until the next rising edge.
   task automatic do_tick(input string name, input int wave, input int mode, input bit act);
      exp_t e, got;
      int src;
      int vo;
      logic [9:0] held_p;
      @(negedge clock);
      bus.active = act;
      if (mode == MODE_PRE) begin
         bus.wave_height = 10'(wave);
         bus.wave_ready  = 1'b1;
         m_wave_q = wave;
         @(negedge clock);
         bus.wave_ready = 1'b0;
      end
      @(negedge clock);
      bus.vsync = 1'b1;
      if (mode == MODE_BYPASS) begin
         bus.wave_height = 10'(wave);
         bus.wave_ready  = 1'b1;
         m_wave_q = wave;
      end
      src = m_wave_q;
      model_tick(src, act, e);
      exp_q.push_back(e);
      @(posedge clock);
      #1;
      bus.wave_ready = 1'b0;
      got = exp_q.pop_front();
      vo = $signed(bus.velocity);
      total++;
      if (int'(bus.p_vpos) !== got.p || vo !== got.v || int'(bus.char_frame) !== got.f
          || bus.airborne !== got.air || bus.landed !== got.land) begin
         bad++;
         $display("FAIL %s: got p=%0d v=%0d f=%0d air=%0b land=%0b, want p=%0d v=%0d f=%0d air=%0b land=%0b",
                  name, bus.p_vpos, vo, bus.char_frame, bus.airborne, bus.landed,
                  got.p, got.v, got.f, got.air, got.land);
      end else begin
         $display("tick %s: p=%0d v=%0d f=%0d air=%0b land=%0b", name, bus.p_vpos, vo,
                  bus.char_frame, bus.airborne, bus.landed);
      end
      held_p = bus.p_vpos;
      repeat (2) @(posedge clock);
      #1;
      total++;
      if (bus.p_vpos !== held_p || bus.landed !== 1'b0) begin
         bad++;
         $display("FAIL %s_hold: got p=%0d land=%0b, want p=%0d land=0", name,
                  bus.p_vpos, bus.landed, held_p);
      end
      @(negedge clock);
      bus.vsync = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus.vsync = 1'b0; bus.active = 1'b1; bus.wave_height = 10'd0; bus.wave_ready = 1'b0;
      repeat (3) @(posedge clock);
      #2;
      total++;
      if (bus.p_vpos !== 10'd300 || bus.velocity !== 8'sd0 || bus.char_frame !== 2'd0
          || bus.airborne !== 1'b0 || bus.landed !== 1'b0) begin
         bad++;
         $display("FAIL reset: got p=%0d v=%0d f=%0d air=%0b land=%0b, want p=300 v=0 f=0 air=0 land=0",
                  bus.p_vpos, bus.velocity, bus.char_frame, bus.airborne, bus.landed);
      end else begin
         $display("reset: p=%0d", bus.p_vpos);
      end
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic test_ride();
      for (int i = 0; i < 3; i++) do_tick("ride_flat", 320, MODE_PRE, 1'b1);
      do_tick("ride_rise", 315, MODE_PRE, 1'b1);
   endtask

   task automatic test_launch_arc();
      int n;
      do_tick("launch", 340, MODE_PRE, 1'b1);
      n = 0;
      while (m_air && n < 40) begin
         do_tick("arc", 340, MODE_NONE, 1'b1);
         n++;
      end
      total++;
      if (bus.p_vpos !== 10'd320 || bus.velocity !== 8'sd0 || bus.airborne !== 1'b0) begin
         bad++;
         $display("FAIL arc_end: got p=%0d v=%0d air=%0b, want p=320 v=0 air=0",
                  bus.p_vpos, bus.velocity, bus.airborne);
      end
   endtask

   task automatic test_top_clamp();
      do_tick("big_rise", 51, MODE_PRE, 1'b1);
      do_tick("rise_7", 44, MODE_PRE, 1'b1);
      do_tick("launch_up", 340, MODE_PRE, 1'b1);
      do_tick("top_clamp", 340, MODE_NONE, 1'b1);
   endtask

   task automatic test_inactive();
      int n;
      n = 0;
      while (m_p < 150 && n < 40) begin
         do_tick("fall", 340, MODE_NONE, 1'b1);
         n++;
      end
      do_tick("inactive", 320, MODE_PRE, 1'b0);
   endtask

   task automatic test_bypass();
      do_tick("settle", 320, MODE_PRE, 1'b1);
      do_tick("bypass_ride", 322, MODE_BYPASS, 1'b1);
      do_tick("bypass_launch", 400, MODE_BYPASS, 1'b1);
      do_tick("after_bypass", 400, MODE_NONE, 1'b1);
   endtask

   task automatic test_async_reset();
      @(negedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      total++;
      if (bus.p_vpos !== 10'd300 || bus.velocity !== 8'sd0 || bus.char_frame !== 2'd0
          || bus.airborne !== 1'b0 || bus.landed !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: got p=%0d v=%0d f=%0d air=%0b, want p=300 v=0 f=0 air=0",
                  bus.p_vpos, bus.velocity, bus.char_frame, bus.airborne);
      end else begin
         $display("async_reset: p=%0d", bus.p_vpos);
      end
      #3;
      reset_n = 1'b1;
      model_reset();
      do_tick("post_reset", 320, MODE_NONE, 1'b1);
   endtask

   task automatic test_back_to_back();
      do_tick("b2b_0", 318, MODE_BYPASS, 1'b1);
      do_tick("b2b_1", 316, MODE_BYPASS, 1'b1);
      do_tick("b2b_2", 330, MODE_BYPASS, 1'b1);
      do_tick("b2b_3", 330, MODE_NONE, 1'b1);
   endtask

   initial begin
      test_reset();
      test_ride();
      test_launch_arc();
      test_top_clamp();
      test_inactive();
      test_bypass();
      test_async_reset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
